// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte-addressable little-endian data memory plus the MEM/WB register.
// Loads read combinationally. Stores and MEM/WB updates happen on the rising clock edge.
module mem_access_stage #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_reg_in,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] alu_data_out,
    output logic [31:0] dm_data_out,
    output logic        misaligned
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_half;
    logic          is_word;
    logic          mis_addr;
    logic          fault;
    logic          commit;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;
    logic [31:0]   wr_word;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;

    assign idx      = alu_result_in[2 +: AW];
    assign lane     = alu_result_in[1:0];
    assign rd_word  = mem[idx];
    assign is_half  = (mem_size_in == 2'b01);
    assign is_word  = mem_size_in[1];
    assign mis_addr = (is_half & lane[0]) | (is_word & (|lane));
    assign fault    = (mem_read_in | mem_write_in) & mis_addr;
    assign commit   = mem_write_in & ~stall & ~flush & ~mis_addr;

    always_comb begin
        byte_val  = rd_word[{lane, 3'b000} +: 8];
        half_val  = rd_word[{lane[1], 4'b0000} +: 16];
        load_data = rd_word;
        case (mem_size_in)
            2'b00:   load_data = {{24{~load_unsigned_in & byte_val[7]}}, byte_val};
            2'b01:   load_data = {{16{~load_unsigned_in & half_val[15]}}, half_val};
            default: load_data = rd_word;
        endcase
    end

    // Merge store data into the current word so only the addressed lanes change.
    always_comb begin
        wr_word = rd_word;
        case (mem_size_in)
            2'b00:   wr_word[{lane, 3'b000} +: 8] = write_data_in[7:0];
            2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = write_data_in[15:0];
            default: wr_word = write_data_in;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_to_reg   <= 1'b0;
            reg_write    <= 1'b0;
            write_reg    <= '0;
            alu_data_out <= '0;
            dm_data_out  <= '0;
            misaligned   <= 1'b0;
        end else if (flush) begin
            mem_to_reg   <= 1'b0;
            reg_write    <= 1'b0;
            write_reg    <= '0;
            alu_data_out <= '0;
            dm_data_out  <= '0;
            misaligned   <= 1'b0;
        end else if (!stall) begin
            mem_to_reg   <= mem_to_reg_in;
            reg_write    <= reg_write_in & ~fault;
            write_reg    <= write_reg_in;
            alu_data_out <= alu_result_in;
            dm_data_out  <= mem_read_in ? load_data : 32'd0;
            misaligned   <= fault;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized traffic checked against
// a byte-array model of the memory and the MEM/WB register.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall, flush, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic [1:0]  mem_size_in;
    logic        load_unsigned_in;
    logic [31:0] alu_result_in, write_data_in;
    logic [4:0]  write_reg_in;
    logic        mem_to_reg, reg_write, misaligned;
    logic [4:0]  write_reg;
    logic [31:0] alu_data_out, dm_data_out;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mb [256];
    logic        exp_rw, exp_mtr, exp_mis, exp_dm_chk;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_alu, exp_dm;

    mem_access_stage #(.DEPTH(64)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .mem_size_in(mem_size_in), .load_unsigned_in(load_unsigned_in),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .write_reg_in(write_reg_in), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .write_reg(write_reg), .alu_data_out(alu_data_out), .dm_data_out(dm_data_out),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mb[i] = 8'h00;
        {exp_rw, exp_mtr, exp_mis, exp_wreg, exp_alu, exp_dm} = '0;
        exp_dm_chk = 1'b1;
    endtask

    task automatic set_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        mem_read_in = rd; mem_write_in = wr; mem_to_reg_in = rd; reg_write_in = rd;
        mem_size_in = sz; load_unsigned_in = uns; alu_result_in = addr;
        write_data_in = wdata; write_reg_in = 5'd7; stall = 1'b0; flush = 1'b0;
    endtask

    // Predict the outcome of one edge from the byte model, then clock and settle.
    task automatic step();
        int n, a;
        bit f, com;
        longint v;
        logic [31:0] wd;
        n = (mem_size_in == 2'd0) ? 1 : (mem_size_in == 2'd1) ? 2 : 4;
        a = int'(alu_result_in % 256);
        f = (mem_read_in || mem_write_in) && (a % n != 0);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mb[(a + i) % 256]) << (8 * i));
        if (!load_unsigned_in && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        com = mem_write_in && !stall && !flush && !f;
        wd = write_data_in;
        if (flush) begin
            {exp_rw, exp_mtr, exp_mis, exp_wreg, exp_alu, exp_dm} = '0;
            exp_dm_chk = 1'b1;
        end else if (!stall) begin
            exp_alu = alu_result_in;
            exp_dm = mem_read_in ? 32'(v) : 32'd0;
            exp_dm_chk = !(mem_read_in && f);
            exp_mtr = mem_to_reg_in;
            exp_wreg = write_reg_in;
            exp_mis = f;
            exp_rw = reg_write_in && !f;
        end
        @(posedge clk);
        if (com) for (int i = 0; i < n; i++) mb[(a + i) % 256] = 8'(wd >> (8 * i));
        #1;
    endtask

    task automatic test_reset();
        set_op(0, 0, 2'd2, 0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({reg_write, mem_to_reg, misaligned, write_reg, alu_data_out, dm_data_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h %h exp=0", alu_data_out, dm_data_out);
        end
        @(posedge clk); #3 reset = 1'b0;
        model_reset();
        set_op(1, 0, 2'd2, 0, 32'h10, 32'h0);
        step();
        checks++;
        if (dm_data_out !== 32'h0 || alu_data_out !== 32'h10) begin
            failures++;
            $display("FAIL reset_mem_zero got=%h alu=%h exp=0 alu=10", dm_data_out, alu_data_out);
        end
    endtask

    task automatic test_word_roundtrip();
        set_op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF); step();
        checks++;
        if (reg_write !== 1'b0 || dm_data_out !== 32'h0) begin
            failures++;
            $display("FAIL rt_store_out got=%b/%h exp=0/0", reg_write, dm_data_out);
        end
        set_op(1, 0, 2'd2, 0, 32'h10, 32'h0); step();
        checks++;
        if (dm_data_out !== 32'hDEADBEEF || reg_write !== 1'b1 || mem_to_reg !== 1'b1) begin
            failures++;
            $display("FAIL rt_load got=%h rw=%b mtr=%b exp=deadbeef 1 1",
                     dm_data_out, reg_write, mem_to_reg);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp_v [6];
        exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FFAB01, 32'h1234AB01,
                  32'h0000AB01};
        set_op(0, 1, 2'd2, 0, 32'h20, 32'h80FF7F01); step();
        set_op(1, 0, 2'd0, 0, 32'h23, 32'h0); step();
        checks++;
        if (dm_data_out !== exp_v[0]) begin
            failures++; $display("FAIL lb_signed got=%h exp=%h", dm_data_out, exp_v[0]);
        end
        set_op(1, 0, 2'd0, 1, 32'h23, 32'h0); step();
        checks++;
        if (dm_data_out !== exp_v[1]) begin
            failures++; $display("FAIL lbu got=%h exp=%h", dm_data_out, exp_v[1]);
        end
        set_op(1, 0, 2'd1, 0, 32'h22, 32'h0); step();
        checks++;
        if (dm_data_out !== exp_v[2]) begin
            failures++; $display("FAIL lh_signed got=%h exp=%h", dm_data_out, exp_v[2]);
        end
        set_op(0, 1, 2'd0, 0, 32'h21, 32'hFFFFFFAB); step();
        set_op(1, 0, 2'd2, 0, 32'h20, 32'h0); step();
        checks++;
        if (dm_data_out !== exp_v[3]) begin
            failures++; $display("FAIL sb_lane got=%h exp=%h", dm_data_out, exp_v[3]);
        end
        set_op(0, 1, 2'd1, 0, 32'h22, 32'hFFFF1234); step();
        set_op(1, 0, 2'd3, 0, 32'h20, 32'h0); step();
        checks++;
        if (dm_data_out !== exp_v[4]) begin
            failures++; $display("FAIL sh_lane_size3 got=%h exp=%h", dm_data_out, exp_v[4]);
        end
        set_op(1, 0, 2'd1, 1, 32'h20, 32'h0); step();
        checks++;
        if (dm_data_out !== exp_v[5]) begin
            failures++; $display("FAIL lhu got=%h exp=%h", dm_data_out, exp_v[5]);
        end
    endtask

    task automatic test_misaligned();
        set_op(0, 1, 2'd2, 0, 32'h21, 32'hCAFEF00D); step();
        checks++;
        if (misaligned !== 1'b1) begin
            failures++; $display("FAIL mis_store got=%b exp=1", misaligned);
        end
        set_op(1, 0, 2'd2, 0, 32'h20, 32'h0); step();
        checks++;
        if (misaligned !== 1'b0 || dm_data_out !== 32'h1234AB01) begin
            failures++;
            $display("FAIL mis_unchanged got=%b/%h exp=0/1234ab01", misaligned, dm_data_out);
        end
        set_op(1, 0, 2'd1, 0, 32'h21, 32'h0); step();
        checks++;
        if (misaligned !== 1'b1 || reg_write !== 1'b0) begin
            failures++;
            $display("FAIL mis_load got=%b rw=%b exp=1 rw=0", misaligned, reg_write);
        end
    endtask

    task automatic test_stall_flush();
        set_op(0, 1, 2'd2, 0, 32'h30, 32'hAAAAAAAA); step();
        set_op(1, 0, 2'd2, 0, 32'h20, 32'h0); step();
        set_op(0, 1, 2'd2, 0, 32'h30, 32'h55); stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (alu_data_out !== 32'h20 || dm_data_out !== 32'h1234AB01 || reg_write !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold c=%0d got=%h/%h/%b exp=20/1234ab01/1", c,
                         alu_data_out, dm_data_out, reg_write);
            end
        end
        flush = 1'b1; step();
        checks++;
        if ({reg_write, mem_to_reg, misaligned, write_reg, alu_data_out, dm_data_out} !== '0) begin
            failures++; $display("FAIL flush_bubble got=%h/%h exp=0", alu_data_out, dm_data_out);
        end
        set_op(1, 0, 2'd2, 0, 32'h30, 32'h0); step();
        checks++;
        if (dm_data_out !== 32'hAAAAAAAA) begin
            failures++; $display("FAIL stall_no_commit got=%h exp=aaaaaaaa", dm_data_out);
        end
        set_op(0, 1, 2'd2, 0, 32'h30, 32'h55); stall = 1'b1;
        repeat (3) step();
        stall = 1'b0; step();
        set_op(1, 0, 2'd2, 0, 32'h30, 32'h0); step();
        checks++;
        if (dm_data_out !== 32'h55) begin
            failures++; $display("FAIL stall_release got=%h exp=55", dm_data_out);
        end
        set_op(0, 1, 2'd2, 0, 32'h34, 32'h77); flush = 1'b1; step();
        set_op(1, 0, 2'd2, 0, 32'h34, 32'h0); step();
        checks++;
        if (dm_data_out !== 32'h0) begin
            failures++; $display("FAIL flush_no_write got=%h exp=0", dm_data_out);
        end
        set_op(1, 1, 2'd2, 0, 32'h30, 32'h66); step();
        set_op(1, 0, 2'd2, 0, 32'h30, 32'h0); step();
        checks++;
        if (dm_data_out !== 32'h66) begin
            failures++; $display("FAIL rw_same_commit got=%h exp=66", dm_data_out);
        end
    endtask

    task automatic test_wrap_reset();
        set_op(0, 1, 2'd2, 0, 32'h104, 32'h12345678); step();
        set_op(1, 0, 2'd2, 0, 32'h004, 32'h0); step();
        checks++;
        if (dm_data_out !== 32'h12345678 || alu_data_out !== 32'h4) begin
            failures++;
            $display("FAIL wrap got=%h alu=%h exp=12345678 alu=4", dm_data_out, alu_data_out);
        end
        set_op(0, 1, 2'd2, 0, 32'h004, 32'h99999999);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({reg_write, mem_to_reg, misaligned, write_reg, alu_data_out, dm_data_out} !== '0) begin
            failures++; $display("FAIL async_reset got=%h/%h exp=0", alu_data_out, dm_data_out);
        end
        @(posedge clk); #3 reset = 1'b0;
        model_reset();
        set_op(1, 0, 2'd2, 0, 32'h004, 32'h0); step();
        checks++;
        if (dm_data_out !== 32'h0 || alu_data_out !== 32'h4 || reg_write !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_load got=%h alu=%h exp=0 alu=4", dm_data_out, alu_data_out);
        end
    endtask

    task automatic test_passthrough();
        set_op(0, 0, 2'd2, 0, 32'h5, 32'h0); step();
        checks++;
        if (alu_data_out !== 32'h5 || dm_data_out !== 32'h0 || mem_to_reg !== 1'b0 ||
            misaligned !== 1'b0) begin
            failures++;
            $display("FAIL passthrough got=%h/%h/%b/%b exp=5/0/0/0", alu_data_out, dm_data_out,
                     mem_to_reg, misaligned);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            mem_read_in = 1'($urandom_range(0, 1));
            mem_write_in = 1'($urandom_range(0, 1));
            mem_to_reg_in = 1'($urandom_range(0, 1));
            reg_write_in = 1'($urandom_range(0, 1));
            mem_size_in = 2'($urandom_range(0, 3));
            load_unsigned_in = 1'($urandom_range(0, 1));
            alu_result_in = $urandom();
            alu_result_in[7:0] = 8'($urandom_range(0, 63));
            write_data_in = $urandom();
            write_reg_in = 5'($urandom_range(0, 31));
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            step();
            checks++;
            if ({reg_write, mem_to_reg, misaligned, write_reg, alu_data_out} !==
                {exp_rw, exp_mtr, exp_mis, exp_wreg, exp_alu}) begin
                failures++;
                $display("FAIL rand_ctl k=%0d got=%b%b%b %h %h exp=%b%b%b %h %h", k, reg_write,
                         mem_to_reg, misaligned, write_reg, alu_data_out, exp_rw, exp_mtr,
                         exp_mis, exp_wreg, exp_alu);
            end
            if (exp_dm_chk) begin
                checks++;
                if (dm_data_out !== exp_dm) begin
                    failures++;
                    $display("FAIL rand_dm k=%0d got=%h exp=%h", k, dm_data_out, exp_dm);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_word_roundtrip();
        test_byte_lanes();
        test_misaligned();
        test_stall_flush();
        test_passthrough();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
